// File: rtl/sine_pkg.sv
// Shared constants and phase-word field helpers for the quarter-wave sine path.
package sine_pkg;

    localparam int    SINE_LAT      = 4;
    localparam string SINE_ROM_FILE = "sine_quarter.hex";

    function automatic int sine_n(input int addr_wdth);
        return 1 << (addr_wdth - 2);
    endfunction

    function automatic int phase_neg_bit(input int addr_wdth, input int cntr_wdth);
        return addr_wdth + cntr_wdth - 1;
    endfunction

    function automatic int phase_inv_bit(input int addr_wdth, input int cntr_wdth);
        return addr_wdth + cntr_wdth - 2;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table, N+1 entries, two read ports with registered outputs.
module sine_quarter_rom
    import sine_pkg::*;
#(
    parameter int    DATA_WDTH = 24,
    parameter int    ADDR_WDTH = 12,
    parameter string ROM_FILE  = SINE_ROM_FILE
) (
    input  logic                 clk,
    input  logic [ADDR_WDTH-2:0] addr_a,
    input  logic [ADDR_WDTH-2:0] addr_b,
    output logic [DATA_WDTH-1:0] data_a,
    output logic [DATA_WDTH-1:0] data_b
);

    localparam int N = sine_n(ADDR_WDTH);

    logic [DATA_WDTH-1:0] mem [0:N];

    initial begin
        for (int i = 0; i <= N; i++) begin
            mem[i] = DATA_WDTH'($rtoi((2.0 ** (DATA_WDTH - 1) - 1.0)
                     * $sin(3.141592653589793 / 2.0 * i / N) + 0.5));
        end
    end

    always_ff @(posedge clk) begin
        data_a <= mem[addr_a];
        data_b <= mem[addr_b];
    end

endmodule

// File: rtl/sine_interp_lookup.sv
// Four-stage quarter-wave sine lookup with optional linear interpolation and channel tag.
module sine_interp_lookup
    import sine_pkg::*;
#(
    parameter int    DATA_WDTH = 24,
    parameter int    ADDR_WDTH = 12,
    parameter int    CNTR_WDTH = 4,
    parameter int    CHAN_WDTH = 2,
    parameter string ROM_FILE  = SINE_ROM_FILE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [CHAN_WDTH-1:0]           in_chan,
    input  logic [ADDR_WDTH+CNTR_WDTH-1:0] in_phase,
    input  logic                           interp_en,
    output logic                           out_valid,
    output logic [CHAN_WDTH-1:0]           out_chan,
    output logic [DATA_WDTH-1:0]           out_sine
);

    localparam int PH_WDTH  = ADDR_WDTH + CNTR_WDTH;
    localparam int Q_WDTH   = ADDR_WDTH - 2 + CNTR_WDTH;
    localparam int IDX_WDTH = ADDR_WDTH - 1;
    localparam int P_WDTH   = DATA_WDTH + CNTR_WDTH + 2;
    localparam int N        = sine_n(ADDR_WDTH);
    localparam int NEG_BIT  = phase_neg_bit(ADDR_WDTH, CNTR_WDTH);
    localparam int INV_BIT  = phase_inv_bit(ADDR_WDTH, CNTR_WDTH);
    localparam logic [Q_WDTH:0]     Q_TOP   = (Q_WDTH + 1)'(N << CNTR_WDTH);
    localparam logic [IDX_WDTH-1:0] IDX_TOP = IDX_WDTH'(N);

    logic [PH_WDTH-1:0]   s0_phase;
    logic [CHAN_WDTH-1:0] s0_chan, s1_chan, s2_chan;
    logic                 s0_interp;
    logic                 s0_valid, s1_valid, s2_valid;
    logic                 s1_neg, s2_neg;
    logic [CNTR_WDTH-1:0] s1_f;
    logic [DATA_WDTH-1:0] y0, y1, s2_y0;
    logic signed [P_WDTH-1:0] s2_p;

    logic [Q_WDTH:0]       s0_qr;
    logic [IDX_WDTH-1:0]   s0_idx, s0_idx_b;
    logic [CNTR_WDTH-1:0]  s0_f;
    logic signed [DATA_WDTH:0] s1_d;
    logic signed [P_WDTH-1:0]  s1_p, s3_m;

    // Fold the second quarter back onto the table: q' = N<<CNTR_WDTH - q.
    assign s0_qr    = s0_phase[INV_BIT] ? Q_TOP - {1'b0, s0_phase[Q_WDTH-1:0]}
                                        : {1'b0, s0_phase[Q_WDTH-1:0]};
    assign s0_idx   = s0_qr[Q_WDTH:CNTR_WDTH];
    assign s0_f     = s0_interp ? s0_qr[CNTR_WDTH-1:0] : '0;
    assign s0_idx_b = (s0_idx == IDX_TOP) ? s0_idx : s0_idx + IDX_WDTH'(1);

    sine_quarter_rom #(
        .DATA_WDTH (DATA_WDTH),
        .ADDR_WDTH (ADDR_WDTH),
        .ROM_FILE  (ROM_FILE)
    ) u_rom (
        .clk    (clk),
        .addr_a (s0_idx),
        .addr_b (s0_idx_b),
        .data_a (y0),
        .data_b (y1)
    );

    assign s1_d = $signed({1'b0, y1}) - $signed({1'b0, y0});
    assign s1_p = P_WDTH'(s1_d) * P_WDTH'($signed({1'b0, s1_f}));
    assign s3_m = P_WDTH'($signed({1'b0, s2_y0})) + (s2_p >>> CNTR_WDTH);

    always_ff @(posedge clk) begin
        s0_phase  <= in_phase;
        s0_chan   <= in_chan;
        s0_interp <= interp_en;
        s1_f      <= s0_f;
        s1_neg    <= s0_phase[NEG_BIT];
        s1_chan   <= s0_chan;
        s2_p      <= s1_p;
        s2_y0     <= y0;
        s2_neg    <= s1_neg;
        s2_chan   <= s1_chan;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_sine  <= '0;
        end else begin
            s0_valid  <= in_valid;
            s1_valid  <= s0_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_chan <= s2_chan;
                out_sine <= s2_neg ? DATA_WDTH'(-s3_m) : DATA_WDTH'(s3_m);
            end
        end
    end

endmodule

// File: tb/tb_sine_interp_lookup.sv
// Directed and model-checked bench for sine_interp_lookup at default parameters.
module tb_sine_interp_lookup;
    import sine_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_chan;
    logic [15:0] in_phase;
    logic        interp_en;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic [23:0] out_sine;

    typedef struct {
        int         due;
        logic [1:0] chan;
        longint     val;
        int         id;
    } exp_t;

    exp_t   exp_q[$];
    longint rom_tbl [0:1024];
    int     cyc = 0;
    int     id_cnt = 0;
    int     err_cnt = 0;
    int     chk_cnt = 0;
    longint last_sine = 0;
    logic [1:0] last_chan = '0;

    sine_interp_lookup #(
        .DATA_WDTH (24),
        .ADDR_WDTH (12),
        .CNTR_WDTH (4),
        .CHAN_WDTH (2),
        .ROM_FILE  ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_chan   (in_chan),
        .in_phase  (in_phase),
        .interp_en (interp_en),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_sine  (out_sine)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint model(input logic [15:0] ph, input logic ie);
        int q, qp, idx, f;
        longint y0, y1, m;
        q   = int'(ph[13:0]);
        qp  = ph[14] ? 16384 - q : q;
        idx = qp / 16;
        f   = ie ? qp % 16 : 0;
        y0  = rom_tbl[idx];
        y1  = rom_tbl[(idx == 1024) ? 1024 : idx + 1];
        m   = y0 + (((y1 - y0) * f) >>> 4);
        return ph[15] ? -m : m;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            exp_q.delete();
            last_sine = 0;
            last_chan = '0;
        end
        if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk($sformatf("out_valid#%0d", e.id), out_valid, 1);
            last_sine = e.val;
            last_chan = e.chan;
            chk($sformatf("out_chan#%0d", e.id), out_chan, last_chan);
            chk($sformatf("out_sine#%0d", e.id), $signed(out_sine), last_sine);
        end else begin
            chk($sformatf("out_valid_idle@%0d", cyc), out_valid, 0);
            chk($sformatf("out_chan_hold@%0d", cyc), out_chan, last_chan);
            chk($sformatf("out_sine_hold@%0d", cyc), $signed(out_sine), last_sine);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] ch,
                         input logic [15:0] ph, input logic ie, input longint ev);
        rst       = r;
        in_valid  = v;
        in_chan   = ch;
        in_phase  = ph;
        interp_en = ie;
        if (v && !r) begin
            exp_q.push_back('{cyc + SINE_LAT, ch, ev, id_cnt});
            id_cnt++;
        end
        tick();
    endtask

    initial begin
        logic [15:0] ph;
        logic        ie;
        for (int i = 0; i <= 1024; i++)
            rom_tbl[i] = longint'($rtoi(8388607.0 * $sin(3.141592653589793 * i / 2048.0) + 0.5));

        // Reset with valid input held high, then idle after release.
        for (int i = 0; i < 3; i++) drive(1, 1, 2'd3, 16'h4000, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 2'd0, 16'h0000, 0, 0);

        // Cardinal points, back to back.
        drive(0, 1, 2'd0, 16'h0000, 1, 0);
        drive(0, 1, 2'd1, 16'h4000, 1, 8388607);
        drive(0, 1, 2'd2, 16'h8000, 1, 0);
        drive(0, 1, 2'd3, 16'hC000, 1, -8388607);
        for (int i = 0; i < 5; i++) drive(0, 0, 2'd0, 16'h0000, 0, 0);

        // Interpolation, truncation and quarter/half symmetry.
        drive(0, 1, 2'd1, 16'h0008, 1, 6434);
        drive(0, 1, 2'd2, 16'h0008, 0, 0);
        drive(0, 1, 2'd3, 16'h0010, 1, 12868);
        drive(0, 1, 2'd0, 16'h4008, 1, 8388602);
        drive(0, 1, 2'd1, 16'h3FF8, 1, 8388602);
        drive(0, 1, 2'd2, 16'hC008, 1, -8388602);
        drive(0, 1, 2'd3, 16'h3FF8, 0, 8388597);
        for (int i = 0; i < 5; i++) drive(0, 0, 2'd0, 16'h0000, 0, 0);

        // Sixteen consecutive samples with cycling tags against the model.
        for (int i = 0; i < 16; i++) begin
            ph = 16'($urandom_range(0, 65535));
            ie = 1'($urandom_range(0, 1));
            drive(0, 1, 2'(i), ph, ie, model(ph, ie));
        end
        for (int i = 0; i < 5; i++) drive(0, 0, 2'd0, 16'h0000, 0, 0);

        // Reset while three samples are in flight; none may emerge.
        drive(0, 1, 2'd1, 16'h1234, 1, model(16'h1234, 1));
        drive(0, 1, 2'd2, 16'h5678, 1, model(16'h5678, 1));
        drive(0, 1, 2'd3, 16'h9ABC, 1, model(16'h9ABC, 1));
        drive(1, 0, 2'd0, 16'h0000, 0, 0);
        drive(0, 1, 2'd2, 16'h4000, 1, 8388607);
        for (int i = 0; i < 6; i++) drive(0, 0, 2'd0, 16'h0000, 0, 0);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
